param_cache_ctrl: RTL and testbench
===================================

Name: param_cache_ctrl

Overview:
- Parametrised N-way set-associative, write-back, write-allocate cache controller; successor to the fixed direct-mapped instruction-cache FSM.
- Sits between the CPU pipeline fetch/memory stage and the word-wide main-memory port.
- Serves reads and writes. Refills and writes back whole lines, one word per memory handshake.
- Replacement: per-set round-robin, with invalid ways filled first.

Parameters:
- ADDR_W, 32, byte address width
- DATA_W, 32, word width; fixed at 32 in this generation (byte offset = 2 bits)
- SETS, 16, number of sets; power of 2, >=2
- WAYS, 2, associativity; power of 2, 1..8
- LINE_WORDS, 4, words per line; power of 2, >=1

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  synchronous active-low reset; asserted when 0, sampled on rising clk
- cpu_req_addr  in  ADDR_W  byte address; bits[1:0] ignored
- cpu_req_valid  in  1  request valid; held stable until cpu_req_ready
- cpu_req_wr  in  1  1 = write, 0 = read
- cpu_req_wdata  in  DATA_W  write data
- cpu_req_data  out  DATA_W  read data; valid while cpu_req_ready=1
- cpu_req_ready  out  1  one-cycle completion pulse
- mem_req_addr  out  ADDR_W  word address to memory
- mem_req_valid  out  1  memory request valid
- mem_req_wr  out  1  1 = write-back word, 0 = refill read
- mem_wr_data  out  DATA_W  write-back data
- mem_req_data  in  DATA_W  refill data; valid with mem_req_ready
- mem_req_ready  in  1  memory accepts/returns the current word this cycle

Behaviour:
- Address split:
  - offset = log2(LINE_WORDS) bits above bits[1:0]
  - index = next log2(SETS) bits
  - tag = remaining upper bits
- Per way/set storage: valid, dirty, tag, LINE_WORDS data words. Per set: round-robin pointer of log2(WAYS) bits.
- Reset (rst=0 at a clock edge):
  - State = IDLE; all valid/dirty bits and pointers cleared.
  - Outputs: cpu_req_ready=0, cpu_req_data=0, mem_req_valid=0, mem_req_wr=0, mem_req_addr=0, mem_wr_data=0.
  - Data/tag arrays are not cleared.
  - Reset mid-transaction abandons it. mem_req_valid is 0 from the first cycle after the reset edge, and there is no retry.
- States:
  - IDLE: if cpu_req_valid, latch addr/wr/wdata -> COMPARE_TAG. cpu_req_ready is 0 here except for the completion pulse.
  - COMPARE_TAG: all ways compared in parallel; hit = valid && tag match.
    - Read hit: register the word into cpu_req_data.
    - Write hit: write the word and set dirty.
    - Either hit: pulse cpu_req_ready=1 in the next cycle; -> IDLE.
    - Miss: pick victim = lowest-index invalid way, else the pointer way; then advance the pointer (mod WAYS).
    - Victim valid && dirty -> WRITE_BACK; else -> ALLOCATE.
  - WRITE_BACK: issue LINE_WORDS writes, word k=0..LINE_WORDS-1.
    - mem_req_addr = {victim tag, index, k, 2'b00}; mem_wr_data = victim word k; mem_req_wr=1.
    - mem_req_valid and all fields held until mem_req_ready=1, then advance k.
    - After the last word -> ALLOCATE.
  - ALLOCATE: issue LINE_WORDS reads at {req tag, index, k, 2'b00} with mem_req_wr=0.
    - Capture mem_req_data into word k on each mem_req_ready.
    - After the last word: tag written, valid=1, dirty=0 -> COMPARE_TAG. The retry hits; a pending write then sets dirty.
- Latency:
  - Hit: valid sampled in IDLE at edge N; ready pulse in cycle N+2.
  - Clean miss: 2 + LINE_WORDS x (memory wait + 1) + 2 cycles.
- Handshake:
  - mem_req_valid drops for at least one cycle only between the WRITE_BACK and ALLOCATE phases; back-to-back words within a phase are allowed.
  - The state returns to IDLE in the cycle cpu_req_ready=1. A still-high cpu_req_valid in that cycle is taken as a new request; the CPU must drop it or present the next request.
  - mem_req_ready while mem_req_valid=0 is ignored.
- Boundaries:
  - Refill word-counter wraps to 0 at phase end.
  - Round-robin pointer wraps WAYS-1 -> 0.
  - WAYS=1 degenerates to direct-mapped (pointer is constant 0).
  - LINE_WORDS=1 gives one-word phases (no offset field).
  - Request fields changing while valid is held are ignored (latched copy used).

Optional Feature:
- Macro: CACHE_STATS_EN
- Defined: adds outputs hit_count (out, 32) and miss_count (out, 32).
  - Incremented on each COMPARE_TAG decision; a post-refill retry counts as neither.
  - Both saturate at 0xFFFFFFFF; cleared by reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset: rst=0 for 2 cycles, then read 0x100 -> miss; ALLOCATE reads 0x100, 0x104, 0x108, 0x10C; cpu_req_data = mem word at 0x100; no WRITE_BACK.
- Read hit: after the above, read 0x108 -> cpu_req_ready exactly 2 cycles after valid; data = mem[0x108]; mem_req_valid stays 0.
- Write hit then eviction (SETS=16, WAYS=2, LINE_WORDS=4):
  - Write 0xDEADBEEF to 0x104 (hit).
  - Miss 0x1100 and 0x2100 (same index 0) to force eviction of the 0x100 line.
  - Required: WRITE_BACK to 0x100..0x10C with word 1 = 0xDEADBEEF.
- Memory stall: mem_req_ready held low 5 cycles per word -> mem_req_addr/valid/wr stable across the stall; the refill completes with correct data.
- Reset mid-refill: rst=0 after 2 of 4 refill words -> mem_req_valid=0 next cycle; subsequent read of the same address misses again.
- CACHE_STATS_EN: sequence of 3 misses + 5 hits -> miss_count=3, hit_count=5.

Source files
------------

// File: rtl/param_cache_ctrl_if.sv
// param_cache_ctrl_if: bundles the CPU-side request port and the word-wide
// main-memory port of param_cache_ctrl.
//
// Ports (signals), seen from the cache controller (modport slave):
//   cpu_req_addr/valid/wr/wdata  in   request from the pipeline
//   cpu_req_data, cpu_req_ready  out  read data and one-cycle completion pulse
//   mem_req_addr/valid/wr        out  memory word request
//   mem_wr_data                  out  write-back data
//   mem_req_data, mem_req_ready  in   refill data and memory accept/return
// The master modport is the pipeline + memory side (testbench).
//
// Handshake semantics:
//   CPU side: cpu_req_valid and its fields are held until cpu_req_ready pulses
//   for one cycle. Memory side: mem_req_valid and all request fields are held
//   until a cycle with mem_req_ready=1, and that cycle transfers the word.
//   mem_req_ready while mem_req_valid=0 carries no meaning.
interface param_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0] cpu_req_addr;
  logic              cpu_req_valid;
  logic              cpu_req_wr;
  logic [DATA_W-1:0] cpu_req_wdata;
  logic [DATA_W-1:0] cpu_req_data;
  logic              cpu_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_valid;
  logic              mem_req_wr;
  logic [DATA_W-1:0] mem_wr_data;
  logic [DATA_W-1:0] mem_req_data;
  logic              mem_req_ready;

  modport slave (
    input  cpu_req_addr, cpu_req_valid, cpu_req_wr, cpu_req_wdata,
    input  mem_req_data, mem_req_ready,
    output cpu_req_data, cpu_req_ready,
    output mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data
  );

  modport master (
    output cpu_req_addr, cpu_req_valid, cpu_req_wr, cpu_req_wdata,
    output mem_req_data, mem_req_ready,
    input  cpu_req_data, cpu_req_ready,
    input  mem_req_addr, mem_req_valid, mem_req_wr, mem_wr_data
  );
endinterface

// File: rtl/param_cache_ctrl.sv
// param_cache_ctrl: N-way set-associative, write-back, write-allocate cache
// controller between the pipeline memory stage and a word-wide memory port.
// Lines are refilled / written back one word per memory handshake.
// Replacement: per-set round-robin pointer, invalid ways are filled first.
//
// Ports:
//   clk        in   clock, rising edge
//   rst        in   synchronous active-low reset
//   bus        slave modport of param_cache_ctrl_if (CPU + memory signals)
//   dbg_state  out  current FSM state (0 IDLE, 1 COMPARE_TAG, 2 WRITE_BACK,
//                   3 ALLOCATE)
//   hit_count  out  saturating hit counter   (only with CACHE_STATS_EN)
//   miss_count out  saturating miss counter  (only with CACHE_STATS_EN)
//
// Optional feature macro: CACHE_STATS_EN adds the hit/miss counters.
module param_cache_ctrl #(
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int SETS       = 16,
  parameter int WAYS       = 2,
  parameter int LINE_WORDS = 4
) (
  input  logic                clk,
  input  logic                rst,
  param_cache_ctrl_if.slave   bus,
  output logic [1:0]          dbg_state
`ifdef CACHE_STATS_EN
  ,
  output logic [31:0]         hit_count,
  output logic [31:0]         miss_count
`endif
);

  localparam int OFF_BITS = $clog2(LINE_WORDS);
  localparam int OFF_W    = (OFF_BITS > 0) ? OFF_BITS : 1;
  localparam int IDX_W    = $clog2(SETS);
  localparam int WAY_W    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int TAG_LSB  = 2 + OFF_BITS + IDX_W;
  localparam int TAG_W    = ADDR_W - TAG_LSB;
  localparam logic [OFF_W-1:0] LAST_WORD = OFF_W'(LINE_WORDS - 1);
  localparam logic [WAY_W-1:0] LAST_WAY  = WAY_W'(WAYS - 1);

  typedef enum logic [1:0] {IDLE, COMPARE_TAG, WRITE_BACK, ALLOCATE} state_t;

  state_t state, next_state;

  logic [DATA_W-1:0] data_q  [WAYS][SETS][LINE_WORDS];
  logic [TAG_W-1:0]  tag_q   [WAYS][SETS];
  logic [SETS-1:0]   valid_q [WAYS];
  logic [SETS-1:0]   dirty_q [WAYS];
  logic [WAY_W-1:0]  ptr_q   [SETS];

  // Latched request; later changes on the CPU port are ignored.
  logic [TAG_W-1:0]  req_tag;
  logic [IDX_W-1:0]  req_idx;
  logic [OFF_W-1:0]  req_off;
  logic              req_wr;
  logic [DATA_W-1:0] req_wdata;

  logic [WAY_W-1:0]  victim_q;
  logic [OFF_W-1:0]  word_q;
  logic              retry_q;   // COMPARE_TAG entered from a finished refill

  logic              hit;
  logic [WAY_W-1:0]  hit_way;
  logic [WAY_W-1:0]  victim;
  logic              victim_dirty;
  logic              mem_fire;
  logic              last_word;
  logic [OFF_W-1:0]  next_word;
  logic [TAG_W-1:0]  phase_tag;

  wire unused_addr_bits = ^bus.cpu_req_addr[1:0];

  assign dbg_state = state;
  assign mem_fire  = bus.mem_req_valid && bus.mem_req_ready;
  assign last_word = (word_q == LAST_WORD);
  // Word issued this cycle: the current one when starting a phase, the
  // following one after a transfer.
  assign next_word = bus.mem_req_valid ? word_q + 1'b1 : word_q;
  assign phase_tag = (state == WRITE_BACK) ? tag_q[victim_q][req_idx] : req_tag;

  function automatic logic [ADDR_W-1:0] line_addr(input logic [TAG_W-1:0] tag,
                                                  input logic [IDX_W-1:0] idx,
                                                  input logic [OFF_W-1:0] word);
    logic [ADDR_W-1:0] a;
    a = '0;
    a[ADDR_W-1:TAG_LSB]    = tag;
    a[2+OFF_BITS +: IDX_W] = idx;
    if (LINE_WORDS > 1) a[2 +: OFF_W] = word;
    return a;
  endfunction

  // Parallel tag compare and victim choice. Descending loops leave the
  // lowest matching / lowest invalid way as the winner.
  always_comb begin
    hit     = 1'b0;
    hit_way = '0;
    victim  = ptr_q[req_idx];
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (valid_q[w][req_idx] && (tag_q[w][req_idx] == req_tag)) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[w][req_idx]) victim = WAY_W'(w);
    end
    victim_dirty = valid_q[victim][req_idx] && dirty_q[victim][req_idx];
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:        if (bus.cpu_req_valid) next_state = COMPARE_TAG;
      COMPARE_TAG: begin
        if (hit)               next_state = IDLE;
        else if (victim_dirty) next_state = WRITE_BACK;
        else                   next_state = ALLOCATE;
      end
      WRITE_BACK:  if (mem_fire && last_word) next_state = ALLOCATE;
      ALLOCATE:    if (mem_fire && last_word) next_state = COMPARE_TAG;
      default:     next_state = IDLE;
    endcase
  end

  // Control state, status bits and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state             <= IDLE;
      for (int w = 0; w < WAYS; w++) begin
        valid_q[w] <= '0;
        dirty_q[w] <= '0;
      end
      for (int s = 0; s < SETS; s++) ptr_q[s] <= '0;
      bus.cpu_req_ready <= 1'b0;
      bus.cpu_req_data  <= '0;
      bus.mem_req_valid <= 1'b0;
      bus.mem_req_wr    <= 1'b0;
      bus.mem_req_addr  <= '0;
      bus.mem_wr_data   <= '0;
      req_tag           <= '0;
      req_idx           <= '0;
      req_off           <= '0;
      req_wr            <= 1'b0;
      req_wdata         <= '0;
      victim_q          <= '0;
      word_q            <= '0;
      retry_q           <= 1'b0;
`ifdef CACHE_STATS_EN
      hit_count         <= '0;
      miss_count        <= '0;
`endif
    end else begin
      state             <= next_state;
      bus.cpu_req_ready <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.cpu_req_valid) begin
            req_tag   <= bus.cpu_req_addr[ADDR_W-1:TAG_LSB];
            req_idx   <= bus.cpu_req_addr[2+OFF_BITS +: IDX_W];
            req_off   <= (LINE_WORDS > 1) ? bus.cpu_req_addr[2 +: OFF_W] : '0;
            req_wr    <= bus.cpu_req_wr;
            req_wdata <= bus.cpu_req_wdata;
          end
        end
        COMPARE_TAG: begin
          if (hit) begin
            bus.cpu_req_ready <= 1'b1;
            if (req_wr) dirty_q[hit_way][req_idx] <= 1'b1;
            else        bus.cpu_req_data <= data_q[hit_way][req_idx][req_off];
            retry_q <= 1'b0;
`ifdef CACHE_STATS_EN
            if (!retry_q && (hit_count != '1)) hit_count <= hit_count + 1'b1;
`endif
          end else begin
            victim_q       <= victim;
            word_q         <= '0;
            ptr_q[req_idx] <= (ptr_q[req_idx] == LAST_WAY) ? '0 : ptr_q[req_idx] + 1'b1;
`ifdef CACHE_STATS_EN
            if (!retry_q && (miss_count != '1)) miss_count <= miss_count + 1'b1;
`endif
          end
        end
        WRITE_BACK, ALLOCATE: begin
          if (!bus.mem_req_valid || (bus.mem_req_ready && !last_word)) begin
            // Start the phase or move on to the following word.
            bus.mem_req_valid <= 1'b1;
            bus.mem_req_wr    <= (state == WRITE_BACK);
            bus.mem_req_addr  <= line_addr(phase_tag, req_idx, next_word);
            bus.mem_wr_data   <= data_q[victim_q][req_idx][next_word];
            word_q            <= next_word;
          end else if (bus.mem_req_ready) begin
            // Last word transferred: close the phase; valid stays low one cycle.
            bus.mem_req_valid <= 1'b0;
            bus.mem_req_wr    <= 1'b0;
            word_q            <= '0;
            if (state == ALLOCATE) begin
              valid_q[victim_q][req_idx] <= 1'b1;
              dirty_q[victim_q][req_idx] <= 1'b0;
              retry_q                    <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Data and tag arrays: not cleared by reset, but no writes while in reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      if ((state == COMPARE_TAG) && hit && req_wr)
        data_q[hit_way][req_idx][req_off] <= req_wdata;
      if ((state == ALLOCATE) && mem_fire) begin
        data_q[victim_q][req_idx][word_q] <= bus.mem_req_data;
        if (last_word) tag_q[victim_q][req_idx] <= req_tag;
      end
    end
  end

endmodule

// File: tb/tb_param_cache_ctrl.sv
// tb_param_cache_ctrl: randomized self-checking bench for param_cache_ctrl.
// A flat "truth" memory gives expected read data; a small replacement model
// (valid/dirty/tag per way, round-robin per set) predicts hits, evictions and
// the exact memory traffic. A memory responder serves the memory port with a
// programmable per-word stall and checks each transfer against exp_q.
module tb_param_cache_ctrl;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 32;
  localparam int SETS       = 16;
  localparam int WAYS       = 2;
  localparam int LINE_WORDS = 4;
  localparam int OFF_BITS   = $clog2(LINE_WORDS);
  localparam int IDX_W      = $clog2(SETS);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  param_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();
  logic [1:0] dbg_state;
`ifdef CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  param_cache_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .SETS(SETS), .WAYS(WAYS), .LINE_WORDS(LINE_WORDS)
  ) dut (
    .clk(clk), .rst(rst), .bus(bus), .dbg_state(dbg_state)
`ifdef CACHE_STATS_EN
    , .hit_count(hit_count), .miss_count(miss_count)
`endif
  );

  // ---------------- scoreboard ----------------
  int vectors     = 0;
  int miscompares = 0;
  logic [64:0] exp_q[$];   // {wr, addr, data}; data only meaningful for writes

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- memories ----------------
  logic [31:0] truth   [logic [31:0]];
  logic [31:0] backing [logic [31:0]];

  function automatic logic [31:0] init_word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A0F0F;
  endfunction

  function automatic logic [31:0] truth_get(input logic [31:0] a);
    return truth.exists(a) ? truth[a] : init_word(a);
  endfunction

  function automatic logic [31:0] backing_get(input logic [31:0] a);
    return backing.exists(a) ? backing[a] : init_word(a);
  endfunction

  // ---------------- replacement model ----------------
  bit          m_valid [WAYS][SETS];
  bit          m_dirty [WAYS][SETS];
  logic [31:0] m_tag   [WAYS][SETS];
  int          m_ptr   [SETS];
  int          m_hits   = 0;
  int          m_misses = 0;

  task automatic model_reset();
    for (int w = 0; w < WAYS; w++)
      for (int s = 0; s < SETS; s++) begin
        m_valid[w][s] = 0;
        m_dirty[w][s] = 0;
      end
    for (int s = 0; s < SETS; s++) m_ptr[s] = 0;
    m_hits   = 0;
    m_misses = 0;
  endtask

  task automatic model_access(input logic [31:0] a, input bit wr,
                              output bit hit, output bit wb, output logic [31:0] vline);
    int set;
    int victim;
    logic [31:0] tag;
    set   = int'((a >> (2 + OFF_BITS)) % SETS);
    tag   = a >> (2 + OFF_BITS + IDX_W);
    hit   = 0;
    wb    = 0;
    vline = '0;
    for (int w = 0; w < WAYS; w++)
      if (m_valid[w][set] && m_tag[w][set] == tag) begin
        hit = 1;
        if (wr) m_dirty[w][set] = 1;
      end
    if (hit) begin
      m_hits++;
    end else begin
      m_misses++;
      victim = m_ptr[set];
      for (int w = WAYS - 1; w >= 0; w--) if (!m_valid[w][set]) victim = w;
      m_ptr[set] = (m_ptr[set] + 1) % WAYS;
      if (m_valid[victim][set] && m_dirty[victim][set]) begin
        wb    = 1;
        vline = (m_tag[victim][set] << (2 + OFF_BITS + IDX_W)) | (set << (2 + OFF_BITS));
      end
      m_valid[victim][set] = 1;
      m_tag[victim][set]   = tag;
      m_dirty[victim][set] = wr;
    end
  endtask

  // ---------------- memory responder ----------------
  int   stall        = 0;
  int   wait_cnt     = 0;
  int   hs_count     = 0;
  int   extra_ops    = 0;
  int   busy_cycles  = 0;
  bit   mem_check_en = 1;
  bit   snap_ok      = 0;
  logic [31:0] snap_addr, snap_wdata;
  logic        snap_wr;

  initial begin
    logic [64:0] e;
    bus.mem_req_ready = 1'b0;
    bus.mem_req_data  = '0;
    forever begin
      @(negedge clk);
      if (bus.mem_req_valid) begin
        busy_cycles++;
        if (snap_ok) begin
          check("stall_addr", bus.mem_req_addr, snap_addr);
          check("stall_wr", bus.mem_req_wr, snap_wr);
          if (snap_wr) check("stall_wdata", bus.mem_wr_data, snap_wdata);
        end
        if (wait_cnt < stall) begin
          wait_cnt++;
          bus.mem_req_ready = 1'b0;
          snap_addr  = bus.mem_req_addr;
          snap_wr    = bus.mem_req_wr;
          snap_wdata = bus.mem_wr_data;
          snap_ok    = 1;
        end else begin
          wait_cnt = 0;
          snap_ok  = 0;
          bus.mem_req_ready = 1'b1;
          hs_count++;
          if (bus.mem_req_wr) backing[bus.mem_req_addr] = bus.mem_wr_data;
          else                bus.mem_req_data = backing_get(bus.mem_req_addr);
          if (mem_check_en) begin
            if (exp_q.size() == 0) extra_ops++;
            else begin
              e = exp_q.pop_front();
              check("mem_op", {bus.mem_req_wr, bus.mem_req_addr}, e[64:32]);
              if (bus.mem_req_wr) check("wb_data", bus.mem_wr_data, e[31:0]);
            end
          end
        end
      end else begin
        bus.mem_req_ready = 1'b0;
        wait_cnt = 0;
        snap_ok  = 0;
      end
    end
  end

  // ---------------- driver ----------------
  task automatic do_req(input logic [31:0] addr, input bit wr, input logic [31:0] wdata,
                        input int stall_cycles);
    bit m_hit, m_wb;
    logic [31:0] waddr, vline, rline, exp_data;
    int cnt;
    waddr = addr & ~32'h3;
    rline = waddr & ~32'(LINE_WORDS * 4 - 1);
    stall = stall_cycles;
    model_access(waddr, wr, m_hit, m_wb, vline);
    if (!m_hit) begin
      if (m_wb)
        for (int k = 0; k < LINE_WORDS; k++)
          exp_q.push_back({1'b1, vline + 32'(4 * k), truth_get(vline + 32'(4 * k))});
      for (int k = 0; k < LINE_WORDS; k++)
        exp_q.push_back({1'b0, rline + 32'(4 * k), 32'h0});
    end
    exp_data = truth_get(waddr);
    if (wr) truth[waddr] = wdata;
    busy_cycles = 0;
    extra_ops   = 0;

    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = waddr | 32'($urandom_range(0, 3));
    bus.cpu_req_wr    = wr;
    bus.cpu_req_wdata = wdata;
    @(posedge clk);
    #1;
    // Fields wander while valid is held; the latched copy must be used.
    bus.cpu_req_addr  = $urandom;
    bus.cpu_req_wr    = 1'($urandom);
    bus.cpu_req_wdata = $urandom;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!bus.cpu_req_ready && cnt < 300);
    bus.cpu_req_valid = 1'b0;

    check("ready_seen", bus.cpu_req_ready, 1'b1);
    if (m_hit)     check("hit_latency", cnt, 2);
    else if (!m_wb) check("miss_latency", cnt, 2 + LINE_WORDS * (stall_cycles + 1) + 2);
    if (!wr)   check("rdata", bus.cpu_req_data, exp_data);
    if (m_hit) check("hit_mem_idle", busy_cycles, 0);
    check("mem_ops_left", exp_q.size(), 0);
    check("mem_ops_extra", extra_ops, 0);
    exp_q.delete();
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int cnt;
    bus.cpu_req_valid = 1'b0;
    bus.cpu_req_addr  = '0;
    bus.cpu_req_wr    = 1'b0;
    bus.cpu_req_wdata = '0;
    model_reset();

    // Reset held for two cycles; outputs cleared.
    rst = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cpu_ready", bus.cpu_req_ready, 0);
    check("rst_cpu_data", bus.cpu_req_data, 0);
    check("rst_mem_valid", bus.mem_req_valid, 0);
    check("rst_mem_wr", bus.mem_req_wr, 0);
    check("rst_mem_addr", bus.mem_req_addr, 0);
    check("rst_mem_wdata", bus.mem_wr_data, 0);
    check("rst_state", dbg_state, 0);
    rst = 1'b1;

    // Directed: cold miss, read hit, write hit, eviction of the dirty line.
    do_req(32'h100, 0, 32'h0, 0);
    do_req(32'h108, 0, 32'h0, 0);
    do_req(32'h104, 1, 32'hDEADBEEF, 0);
    do_req(32'h1100, 0, 32'h0, 0);
    do_req(32'h2100, 0, 32'h0, 0);
    check("wb_deadbeef", backing_get(32'h104), 32'hDEADBEEF);
    do_req(32'h1104, 0, 32'h0, 0);
    do_req(32'h2108, 0, 32'h0, 0);
    do_req(32'h110C, 0, 32'h0, 1);
`ifdef CACHE_STATS_EN
    check("stats_miss_3", miss_count, 3);
    check("stats_hit_5", hit_count, 5);
`endif

    // Memory stall of 5 cycles per word on a fresh set.
    do_req(32'h3140, 0, 32'h0, 5);

    // Reset after two of four refill words.
    mem_check_en = 0;
    hs_count     = 0;
    stall        = 0;
    @(negedge clk);
    bus.cpu_req_valid = 1'b1;
    bus.cpu_req_addr  = 32'h4250;
    bus.cpu_req_wr    = 1'b0;
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (hs_count < 2 && cnt < 100);
    check("mid_rst_two_words", hs_count, 2);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.cpu_req_valid = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_mem_valid", bus.mem_req_valid, 0);
    check("mid_rst_cpu_ready", bus.cpu_req_ready, 0);
    rst = 1'b1;
    model_reset();
    exp_q.delete();
    mem_check_en = 1;
    do_req(32'h4250, 0, 32'h0, 0);

    // Randomized traffic over a few sets and tags to force conflicts.
    for (int i = 0; i < 250; i++) begin
      logic [31:0] a;
      a = (32'($urandom_range(0, 5)) << 8) | (32'($urandom_range(0, 3)) << 4) |
          (32'($urandom_range(0, 3)) << 2);
      do_req(a, ($urandom_range(0, 9) < 4), $urandom, $urandom_range(0, 2));
    end
`ifdef CACHE_STATS_EN
    check("stats_hits", hit_count, m_hits);
    check("stats_misses", miss_count, m_misses);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
